// File: rtl/sr_pulse_debouncer_pkg.sv
// Shared constants for the S/R push-button debouncer.
// Hardware defaults assume a 100 MHz clock; the SIM_* values keep benches short.
package sr_pulse_debouncer_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int CNT_W_DEFAULT           = 20;

    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_CNT_W           = 3;

    // The counter must be able to reach DEBOUNCE_CYCLES-1 without wrapping.
    function automatic bit cnt_w_ok(input int cycles, input int w);
        return (64'(1) << w) >= 64'(cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter,
// debounced level and its one-cycle-delayed copy for rise detection.
import sr_pulse_debouncer_pkg::*;

module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    if (DEBOUNCE_CYCLES < 2 || !cnt_w_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad
        $error("debounce_channel: illegal DEBOUNCE_CYCLES/CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    assign mismatch = s2 ^ level;
    assign rise     = level & ~level_d;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after an unbroken run of mismatching samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            level_d <= level;
            if (!mismatch) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_pulse_debouncer.sv
// Two debounced buttons turned into mutually exclusive one-cycle S/R pulses.
// Reset wins any tie, and a set press while reset is held is discarded.
import sr_pulse_debouncer_pkg::*;

module sr_pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S,
    output logic R,
    output logic set_level,
    output logic reset_level
);

    logic rise_set;
    logic rise_reset;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_set),
        .level   (set_level),
        .rise    (rise_set)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reset (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_reset),
        .level   (reset_level),
        .rise    (rise_reset)
    );

    // Registered pulses; R is never masked, S yields to any reset activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            S <= 1'b0;
            R <= 1'b0;
        end else begin
            R <= rise_reset;
            S <= rise_set & ~rise_reset & ~reset_level;
        end
    end

endmodule
